mem_uart_dump_ctrl: RTL
=======================

# mem_uart_dump_ctrl

Sequencer that dumps data-memory contents over a UART TX line after a program finishes. On `start` it reads a word count from address 0, reads words 1..N, and serializes each as 4 bytes, MSB byte first, using 8N1 framing. It sits between the pipeline's Data_Memory read port and the board TX pin, and holds the pipeline off memory (`mem_grant`) while it owns the port.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range ≥2.
- `MAX_WORDS`, 255: clamp for the count read from address 0.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `mem_readEn`  out  1  read strobe to Data_Memory.
- `mem_address`  out  32  word address to Data_Memory.
- `mem_dataOut`  in  32  Data_Memory read data, valid 1 cycle after `mem_readEn`.
- `mem_grant`  out  1  high while this block owns the memory port; pipeline must stall.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from accepting `start` until DONE completes.
- `done`  out  1  one-cycle pulse at end of dump.

## Operation
- States: IDLE, RD_CNT, WAIT_CNT, RD_WORD, WAIT_WORD, TX_START, TX_DATA, (TX_PAR), TX_STOP, DONE.
- IDLE: `tx`=1; `busy`=0; `mem_grant`=0. `start`=1 moves to RD_CNT.
- RD_CNT: `mem_readEn`=1, `mem_address`=0. Next state is WAIT_CNT.
- WAIT_CNT: latch count N = min(`mem_dataOut`, MAX_WORDS), compared as unsigned 32-bit. If N=0, go to DONE. Otherwise set index=1 and go to RD_WORD.
- RD_WORD: `mem_readEn`=1, `mem_address`=index. Next state is WAIT_WORD.
- WAIT_WORD: latch `mem_dataOut` into a 32-bit shift word, set byte_cnt=0, go to TX_START.
- TX_START: `tx`=0 for CLKS_PER_BIT cycles. Load the byte, bits [31:24] of the shift word, into the TX register.
- TX_DATA: send 8 bits LSB first, CLKS_PER_BIT cycles each.
- TX_STOP: `tx`=1 for CLKS_PER_BIT cycles. Then take one of three paths:
  - byte_cnt<3: shift word left 8, byte_cnt++, go to TX_START.
  - byte_cnt=3 and index<N: index++, go to RD_WORD.
  - otherwise: go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `mem_grant`=1 and `busy`=1 in every state except IDLE.
- `mem_readEn`=1 only in RD_CNT and RD_WORD.
- `start` outside IDLE is ignored and not queued.
- Index counter is 8 bits wide when MAX_WORDS ≤255, compared unsigned; no wrap is possible because of the clamp.

## Timing
- Reset values: `tx`=1, `mem_readEn`=0, `mem_address`=0, `mem_grant`=0, `busy`=0, `done`=0, state=IDLE, all counters 0.
- Reset asserted mid-operation: every output returns to its reset value immediately (asynchronous). A partial byte is abandoned; no stop bit is appended.
- `start` sampled at edge k: `busy`, `mem_grant` and `mem_readEn` are high after edge k; the count is latched at edge k+2.
- First start bit begins 4 cycles after the `start` edge: RD_CNT, WAIT_CNT, RD_WORD, WAIT_WORD.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Gap between words: 2 cycles of `tx`=1 (RD_WORD, WAIT_WORD). No gap between bytes within a word.
- Bit timer counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
- Dump of N words: 2 + N·(2 + 4·F) + 1 cycles from `start` to `done` inclusive, where F is the frame length in cycles.

## Configuration
- `DUMP_PARITY_EN` defined:
  - adds state TX_PAR between TX_DATA and TX_STOP;
  - `tx` carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles;
  - frame is 11 bits.
- `DUMP_PARITY_EN` undefined: TX_PAR is absent and the frame is 8N1 (10 bits).

## Test plan
- Single word:
  - stimulus: mem[0]=1, mem[1]=0xAAF00FAA, CLKS_PER_BIT=4, pulse `start`;
  - response: `tx` decodes to bytes 0xAA, 0xF0, 0x0F, 0xAA in that order; `done` pulses once at cycle 2+1·(2+160)+1; `mem_address` sequence is 0, 1.
- Two words:
  - stimulus: mem[0]=2, mem[1]=0xAEF039A8, mem[2]=0x00000001;
  - response: 8 bytes AE F0 39 A8 00 00 00 01; exactly 2 cycles of idle-high between the word frames.
- Zero count:
  - stimulus: mem[0]=0, pulse `start`;
  - response: `tx` stays 1; `done` 3 cycles after `start`; `busy` high exactly 3 cycles.
- Clamp:
  - stimulus: mem[0]=0xFFFFFFFF, MAX_WORDS=3;
  - response: exactly 3 words are sent; last `mem_address` is 3.
- Reset mid-byte:
  - stimulus: drop `rst` during TX_DATA of the second byte, release it, then pulse `start` again;
  - response: during reset `tx`=1, `busy`=0, `mem_grant`=0; after release the dump restarts from address 0.
- Ignored start, with `DUMP_PARITY_EN` defined:
  - stimulus: repeat `start` pulses while `busy`;
  - response: only one dump occurs; byte 0xF0 carries parity bit 0 and byte 0x39 carries parity bit 0; frame is 11·CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/mem_uart_dump_ctrl.sv
// Dumps Data_Memory words 1..N over UART TX, MSB byte first, after reading N from address 0.
// Define DUMP_PARITY_EN to append an even-parity bit to every frame.
module mem_uart_dump_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MAX_WORDS    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_readEn,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_dataOut,
    output logic        mem_grant,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int IDX_W = (MAX_WORDS < 2) ? 1 : $clog2(MAX_WORDS + 1);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0] MAX_CNT = 32'(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        RD_WORD,
        WAIT_WORD,
        TX_START,
        TX_DATA,
`ifdef DUMP_PARITY_EN
        TX_PAR,
`endif
        TX_STOP,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] wordCnt;
    logic [IDX_W-1:0] index;
    logic [TMR_W-1:0] bitTimer;
    logic [2:0]       bitIdx;
    logic [1:0]       byteCnt;
    logic [31:0]      shiftWord;
    logic [7:0]       txByte;
    logic             bitEnd;

    assign bitEnd = (bitTimer == TMR_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wordCnt     <= '0;
            index       <= '0;
            bitTimer    <= '0;
            bitIdx      <= '0;
            byteCnt     <= '0;
            shiftWord   <= '0;
            txByte      <= '0;
            mem_readEn  <= 1'b0;
            mem_address <= '0;
            mem_grant   <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_CNT;
                        mem_readEn  <= 1'b1;
                        mem_address <= '0;
                        mem_grant   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RD_CNT: begin
                    state      <= WAIT_CNT;
                    mem_readEn <= 1'b0;
                end
                WAIT_CNT: begin
                    // Unsigned 32-bit clamp keeps index from ever wrapping.
                    if (mem_dataOut > MAX_CNT) wordCnt <= IDX_W'(MAX_WORDS);
                    else wordCnt <= mem_dataOut[IDX_W-1:0];
                    if (mem_dataOut == 32'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        index       <= IDX_W'(1);
                        state       <= RD_WORD;
                        mem_readEn  <= 1'b1;
                        mem_address <= 32'd1;
                    end
                end
                RD_WORD: begin
                    state      <= WAIT_WORD;
                    mem_readEn <= 1'b0;
                end
                WAIT_WORD: begin
                    shiftWord <= mem_dataOut;
                    byteCnt   <= '0;
                    bitTimer  <= '0;
                    tx        <= 1'b0;
                    state     <= TX_START;
                end
                TX_START: begin
                    if (bitTimer == '0) txByte <= shiftWord[31:24];
                    if (bitEnd) begin
                        bitTimer <= '0;
                        bitIdx   <= '0;
                        tx       <= txByte[0];
                        state    <= TX_DATA;
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bitEnd) begin
                        bitTimer <= '0;
                        if (bitIdx == 3'd7) begin
`ifdef DUMP_PARITY_EN
                            tx    <= ^txByte;
                            state <= TX_PAR;
`else
                            tx    <= 1'b1;
                            state <= TX_STOP;
`endif
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            tx     <= txByte[bitIdx + 3'd1];
                        end
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
`ifdef DUMP_PARITY_EN
                TX_PAR: begin
                    if (bitEnd) begin
                        bitTimer <= '0;
                        tx       <= 1'b1;
                        state    <= TX_STOP;
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (bitEnd) begin
                        bitTimer <= '0;
                        if (byteCnt != 2'd3) begin
                            shiftWord <= {shiftWord[23:0], 8'h00};
                            byteCnt   <= byteCnt + 2'd1;
                            tx        <= 1'b0;
                            state     <= TX_START;
                        end else if (index < wordCnt) begin
                            index       <= index + 1'b1;
                            mem_readEn  <= 1'b1;
                            mem_address <= 32'(index + 1'b1);
                            state       <= RD_WORD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    mem_grant <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
